// File: rtl/config_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_pkg: FPU format configuration and divide-sequencer state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
package config_pkg;

    localparam int NE   = 11;
    localparam int NF   = 52;
    localparam int BIAS = 2**(NE-1) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fdiv_restoring_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fdiv_restoring_step: one radix-2 restoring division step (quotient bit and
// next partial remainder). Rev 1.0
// ---------------------------------------------------------------------------
module fdiv_restoring_step #(
    parameter int NF = 52
) (
    input  logic [NF+2:0] r_in,
    input  logic [NF:0]   d_in,
    output logic          q,
    output logic [NF+2:0] r_out
);

    logic [NF+2:0] d_ext;
    logic [NF+2:0] diff;
    logic [NF+2:0] kept;

    assign d_ext = {2'b00, d_in};
    assign q     = (r_in >= d_ext);
    assign diff  = r_in - d_ext;
    assign kept  = q ? diff : r_in;
    // The kept remainder is always below 2*D, so the shift never loses a set bit.
    assign r_out = kept << 1;

endmodule
`default_nettype wire

// File: rtl/fdiv_expquot_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fdiv_expquot_seq: sequential divide exponent subtract and normalized
// restoring-division quotient, one bit per cycle. Rev 1.0
// ---------------------------------------------------------------------------
module fdiv_expquot_seq
    import config_pkg::*;
#(
    parameter int NE   = config_pkg::NE,
    parameter int NF   = config_pkg::NF,
    parameter int BIAS = config_pkg::BIAS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Start,
    input  logic [NE-1:0] Xe,
    input  logic [NE-1:0] Ye,
    input  logic [NF:0]   Xm,
    input  logic [NF:0]   Ym,
    input  logic          XZero,
    input  logic          YZero,
    output logic          Busy,
    output logic          Done,
    output logic [NE+1:0] Qe,
    output logic [NF+1:0] Qm,
    output logic          Sticky,
    output logic          DivZero
);

    localparam int              CW       = $clog2(NF + 3);
    localparam logic [CW-1:0]   CNT_INIT = CW'(NF + 2);
    localparam logic [NE+1:0]   BIAS_W   = (NE + 2)'(BIAS);

    state_t        state;
    state_t        state_next;
    logic [NE+1:0] qe_raw;
    logic [NF+2:0] rem;
    logic [NF+2:0] rem_next;
    logic [NF:0]   dvs;
    logic [NF+1:0] quot;
    logic [NF+2:0] quot_next;
    logic [CW-1:0] cnt;
    logic          q_bit;
    logic          special;
    logic          last_step;

    assign special   = XZero | YZero;
    assign last_step = (cnt == '0);
    // Only NF+2 quotient bits need storing; the top bit exists only in quot_next.
    assign quot_next = {quot, q_bit};

    fdiv_restoring_step #(
        .NF (NF)
    ) u_step (
        .r_in  (rem),
        .d_in  (dvs),
        .q     (q_bit),
        .r_out (rem_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = special ? DONE : BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            BUSY:    Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qe_raw  <= '0;
            rem     <= '0;
            dvs     <= '0;
            quot    <= '0;
            cnt     <= '0;
            Qe      <= '0;
            Qm      <= '0;
            Sticky  <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        DivZero <= YZero & ~XZero;
                        if (special) begin
                            Qe     <= '0;
                            Qm     <= '0;
                            Sticky <= 1'b0;
                        end else begin
                            qe_raw <= {2'b00, Xe} - {2'b00, Ye} + BIAS_W;
                            rem    <= {2'b00, Xm};
                            dvs    <= Ym;
                            quot   <= '0;
                            cnt    <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    rem  <= rem_next;
                    quot <= quot_next[NF+1:0];
                    if (last_step) begin
                        // Quotient lies in (1/2, 2); a leading zero costs one exponent step.
                        if (quot_next[NF+2]) begin
                            Qm     <= quot_next[NF+2:1];
                            Qe     <= qe_raw;
                            Sticky <= quot_next[0] | (rem_next != '0);
                        end else begin
                            Qm     <= quot_next[NF+1:0];
                            Qe     <= qe_raw - (NE + 2)'(1);
                            Sticky <= (rem_next != '0);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdiv_expquot_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fdiv_expquot_seq: directed self-checking bench, single-precision sizing.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fdiv_expquot_seq;

    localparam int NE = 8;
    localparam int NF = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Start = 1'b0;
    logic [NE-1:0] Xe = '0;
    logic [NE-1:0] Ye = '0;
    logic [NF:0]   Xm = '0;
    logic [NF:0]   Ym = '0;
    logic          XZero = 1'b0;
    logic          YZero = 1'b0;
    logic          Busy;
    logic          Done;
    logic [NE+1:0] Qe;
    logic [NF+1:0] Qm;
    logic          Sticky;
    logic          DivZero;

    int tests = 0;
    int fails = 0;
    int done_cyc;
    int ndone;
    int nbusy;

    fdiv_expquot_seq #(
        .NE   (NE),
        .NF   (NF),
        .BIAS (127)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Xe      (Xe),
        .Ye      (Ye),
        .Xm      (Xm),
        .Ym      (Ym),
        .XZero   (XZero),
        .YZero   (YZero),
        .Busy    (Busy),
        .Done    (Done),
        .Qe      (Qe),
        .Qm      (Qm),
        .Sticky  (Sticky),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; Start is raised here so edge 0 is the next posedge.
    // Observes cycles 1..40, optionally pulsing Start or reset at a given cycle.
    task automatic run_op(input logic [NE-1:0] xe, input logic [NE-1:0] ye,
                          input logic [NF:0] xm, input logic [NF:0] ym,
                          input logic xz, input logic yz,
                          input int inj_start, input int inj_reset,
                          output int dcyc, output int nd, output int nb);
        Xe = xe; Ye = ye; Xm = xm; Ym = ym; XZero = xz; YZero = yz;
        Start = 1'b1;
        dcyc = 0; nd = 0; nb = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (Done) begin
                nd++;
                if (dcyc == 0) dcyc = n;
            end
            if (Busy) nb++;
            if (inj_reset > 0 && n == inj_reset + 1) begin
                check("rst_busy", {63'd0, Busy}, 64'd0);
                check("rst_done", {63'd0, Done}, 64'd0);
                check("rst_qe", {54'd0, Qe}, 64'd0);
                check("rst_qm", {39'd0, Qm}, 64'd0);
                check("rst_sticky", {63'd0, Sticky}, 64'd0);
                check("rst_divzero", {63'd0, DivZero}, 64'd0);
            end
            Start = (n == inj_start);
            reset = (n == inj_reset);
            if (n == inj_start) begin
                Xe = 8'd127; Ye = 8'd127; Xm = 24'h800000; Ym = 24'hC00000;
            end
        end
    endtask

    task automatic check_res(input string tag, input logic [NE+1:0] qe, input logic [NF+1:0] qm,
                             input logic st, input logic dz);
        check({tag, "_qe"}, {54'd0, Qe}, {54'd0, qe});
        check({tag, "_qm"}, {39'd0, Qm}, {39'd0, qm});
        check({tag, "_sticky"}, {63'd0, Sticky}, {63'd0, st});
        check({tag, "_divzero"}, {63'd0, DivZero}, {63'd0, dz});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);
        check_res("reset", 10'd0, 25'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // 3.0 / 1.0
        run_op(8'd128, 8'd127, 24'hC00000, 24'h800000, 1'b0, 1'b0, 0, 0, done_cyc, ndone, nbusy);
        check("div3_done_cycle", 64'(done_cyc), 64'd27);
        check("div3_done_count", 64'(ndone), 64'd1);
        check("div3_busy_cycles", 64'(nbusy), 64'd26);
        check_res("div3", 10'd128, 25'h1800000, 1'b0, 1'b0);

        // 1.0 / 1.5
        run_op(8'd127, 8'd127, 24'h800000, 24'hC00000, 1'b0, 1'b0, 0, 0, done_cyc, ndone, nbusy);
        check("div1p5_done_cycle", 64'(done_cyc), 64'd27);
        check_res("div1p5", 10'd126, 25'h1555555, 1'b1, 1'b0);

        // divide by zero
        run_op(8'd127, 8'd127, 24'h800000, 24'h800000, 1'b0, 1'b1, 0, 0, done_cyc, ndone, nbusy);
        check("yzero_done_cycle", 64'(done_cyc), 64'd1);
        check("yzero_busy_cycles", 64'(nbusy), 64'd0);
        check_res("yzero", 10'd0, 25'd0, 1'b0, 1'b1);

        // zero / zero: no DivZero
        run_op(8'd127, 8'd127, 24'h800000, 24'h800000, 1'b1, 1'b1, 0, 0, done_cyc, ndone, nbusy);
        check("zz_done_cycle", 64'(done_cyc), 64'd1);
        check_res("zz", 10'd0, 25'd0, 1'b0, 1'b0);

        // exponent underflow passthrough
        run_op(8'd1, 8'd254, 24'h800000, 24'h800000, 1'b0, 1'b0, 0, 0, done_cyc, ndone, nbusy);
        check("tiny_done_cycle", 64'(done_cyc), 64'd27);
        check_res("tiny", 10'h382, 25'h1000000, 1'b0, 1'b0);

        // Start during BUSY cycle 5 must be ignored
        run_op(8'd128, 8'd127, 24'hC00000, 24'h800000, 1'b0, 1'b0, 5, 0, done_cyc, ndone, nbusy);
        check("midstart_done_cycle", 64'(done_cyc), 64'd27);
        check("midstart_done_count", 64'(ndone), 64'd1);
        check_res("midstart", 10'd128, 25'h1800000, 1'b0, 1'b0);

        // reset in BUSY cycle 10 abandons the operation
        run_op(8'd127, 8'd127, 24'h800000, 24'hC00000, 1'b0, 1'b0, 0, 10, done_cyc, ndone, nbusy);
        check("rstmid_done_count", 64'(ndone), 64'd0);

        // fresh operation after the abandoned one
        run_op(8'd127, 8'd127, 24'h800000, 24'hC00000, 1'b0, 1'b0, 0, 0, done_cyc, ndone, nbusy);
        check("fresh_done_cycle", 64'(done_cyc), 64'd27);
        check_res("fresh", 10'd126, 25'h1555555, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
